// File: rtl/multi_alarm_clock.sv
// rtl/multi_alarm_clock.sv - time-of-day clock with NA alarms, snooze, dismiss and auto-stop ringing
module multi_alarm_clock #(
  parameter int NS       = 60,
  parameter int NH       = 24,
  parameter int ND       = 7,
  parameter int NA       = 4,
  parameter int SNOOZE_M = 9,
  parameter int RING_S   = 60,
  parameter int AW       = $clog2(NA)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          timeset,
  input  logic          alarmset,
  input  logic [AW-1:0] alarm_sel,
  input  logic          minadv,
  input  logic          hrsadv,
  input  logic          dayadv,
  input  logic [NA-1:0] alarm_en,
  input  logic          snooze,
  input  logic          dismiss,
  output logic [6:0]    sec,
  output logic [6:0]    min,
  output logic [6:0]    hrs,
  output logic [2:0]    day,
  output logic [6:0]    disp_min,
  output logic [6:0]    disp_hrs,
  output logic          buzz,
  output logic [AW-1:0] buzz_id,
  output logic          snoozing
);

  localparam int SW       = $clog2(NS);
  localparam int HW       = $clog2(NH);
  localparam int DW       = $clog2(ND);
  localparam int SNOOZE_T = SNOOZE_M * NS;
  localparam int RW       = $clog2(RING_S);
  localparam int CW       = $clog2(SNOOZE_T);

  localparam logic [SW-1:0] SEC_MAX  = SW'(NS - 1);
  localparam logic [HW-1:0] HRS_MAX  = HW'(NH - 1);
  localparam logic [DW-1:0] DAY_MAX  = DW'(ND - 1);
  localparam logic [RW-1:0] RING_MAX = RW'(RING_S - 1);
  localparam logic [CW-1:0] SNZ_MAX  = CW'(SNOOZE_T - 1);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  logic [SW-1:0] sec_q, min_q, sec_n, min_n;
  logic [HW-1:0] hrs_q, hrs_n;
  logic [DW-1:0] day_q, day_n;
  logic [SW-1:0] al_min [NA];
  logic [HW-1:0] al_hrs [NA];

  state_t        state;
  logic [RW-1:0] rcnt;
  logic [CW-1:0] scnt;

  logic          run;
  logic          edit_alarm;
  logic          hit;
  logic [AW-1:0] hit_id;

  // Normal running only when neither set mode is active; timeset has priority over alarmset.
  assign run        = tick & ~timeset & ~alarmset;
  assign edit_alarm = tick & alarmset & ~timeset;

  // Next time value; the alarm comparators look at this so buzz rises on the HH:MM:00 edge.
  always_comb begin
    sec_n = sec_q;
    min_n = min_q;
    hrs_n = hrs_q;
    day_n = day_q;
    if (tick && timeset) begin
      if (minadv) min_n = (min_q == SEC_MAX) ? '0 : min_q + 1'b1;
      if (hrsadv) hrs_n = (hrs_q == HRS_MAX) ? '0 : hrs_q + 1'b1;
      if (dayadv) day_n = (day_q == DAY_MAX) ? '0 : day_q + 1'b1;
    end else if (run) begin
      if (sec_q == SEC_MAX) begin
        sec_n = '0;
        if (min_q == SEC_MAX) begin
          min_n = '0;
          if (hrs_q == HRS_MAX) begin
            hrs_n = '0;
            day_n = (day_q == DAY_MAX) ? '0 : day_q + 1'b1;
          end else begin
            hrs_n = hrs_q + 1'b1;
          end
        end else begin
          min_n = min_q + 1'b1;
        end
      end else begin
        sec_n = sec_q + 1'b1;
      end
    end
  end

  // Alarm match on the upcoming time; scanning downwards leaves the lowest matching index.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int i = NA - 1; i >= 0; i--) begin
      if (run && alarm_en[i] && sec_n == '0 && min_n == al_min[i] && hrs_n == al_hrs[i]) begin
        hit    = 1'b1;
        hit_id = AW'(i);
      end
    end
  end

  // Time-of-day registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q <= '0;
      min_q <= '0;
      hrs_q <= '0;
      day_q <= '0;
    end else begin
      sec_q <= sec_n;
      min_q <= min_n;
      hrs_q <= hrs_n;
      day_q <= day_n;
    end
  end

  // Alarm registers; the selected alarm's fields advance without carry while in alarm-set mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NA; i++) begin
        al_min[i] <= '0;
        al_hrs[i] <= '0;
      end
    end else if (edit_alarm) begin
      if (minadv) al_min[alarm_sel] <= (al_min[alarm_sel] == SEC_MAX) ? '0 : al_min[alarm_sel] + 1'b1;
      if (hrsadv) al_hrs[alarm_sel] <= (al_hrs[alarm_sel] == HRS_MAX) ? '0 : al_hrs[alarm_sel] + 1'b1;
    end
  end

  // Ringing controller with registered buzz/snoozing/buzz_id; dismiss beats snooze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rcnt     <= '0;
      scnt     <= '0;
      buzz     <= 1'b0;
      snoozing <= 1'b0;
      buzz_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state   <= RINGING;
            rcnt    <= '0;
            buzz_id <= hit_id;
            buzz    <= 1'b1;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state <= IDLE;
            buzz  <= 1'b0;
          end else if (snooze) begin
            state    <= SNOOZE;
            scnt     <= '0;
            buzz     <= 1'b0;
            snoozing <= 1'b1;
          end else if (tick) begin
            if (rcnt == RING_MAX) begin
              state <= IDLE;
              buzz  <= 1'b0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (dismiss) begin
            state    <= IDLE;
            snoozing <= 1'b0;
          end else if (tick) begin
            if (scnt == SNZ_MAX) begin
              state    <= RINGING;
              rcnt     <= '0;
              buzz     <= 1'b1;
              snoozing <= 1'b0;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          buzz     <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

  assign sec      = 7'(sec_q);
  assign min      = 7'(min_q);
  assign hrs      = 7'(hrs_q);
  assign day      = 3'(day_q);
  assign disp_min = alarmset ? 7'(al_min[alarm_sel]) : 7'(min_q);
  assign disp_hrs = alarmset ? 7'(al_hrs[alarm_sel]) : 7'(hrs_q);

endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb/tb_multi_alarm_clock.sv - self-checking bench for multi_alarm_clock
module tb_multi_alarm_clock;
  localparam int NA = 4;
  localparam int AW = 2;
  localparam int WEEK = 7 * 24 * 3600;

  logic          clk = 0, rst = 1, tick = 0, timeset = 0, alarmset = 0;
  logic          minadv = 0, hrsadv = 0, dayadv = 0, snooze = 0, dismiss = 0;
  logic [AW-1:0] alarm_sel = '0;
  logic [NA-1:0] alarm_en = '0;
  logic [6:0]    sec, min, hrs, disp_min, disp_hrs;
  logic [2:0]    day;
  logic          buzz, snoozing;
  logic [AW-1:0] buzz_id;

  int n_vec = 0, n_bad = 0;
  bit chk_on = 0;

  // Reference model: plain integers, time as seconds-in-week, countdowns for ring/snooze.
  int m_sec = 0, m_min = 0, m_hrs = 0, m_day = 0;
  int a_min [NA];
  int a_hrs [NA];
  int m_state = 0, ring_left = 0, snz_left = 0, m_id = 0;

  multi_alarm_clock dut (
    .clk(clk), .rst(rst), .tick(tick), .timeset(timeset), .alarmset(alarmset),
    .alarm_sel(alarm_sel), .minadv(minadv), .hrsadv(hrsadv), .dayadv(dayadv),
    .alarm_en(alarm_en), .snooze(snooze), .dismiss(dismiss),
    .sec(sec), .min(min), .hrs(hrs), .day(day), .disp_min(disp_min), .disp_hrs(disp_hrs),
    .buzz(buzz), .buzz_id(buzz_id), .snoozing(snoozing)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin : model
    int tot;
    bit hit;
    int hid;
    if (!rst) begin
      m_sec = 0; m_min = 0; m_hrs = 0; m_day = 0;
      for (int i = 0; i < NA; i++) begin a_min[i] = 0; a_hrs[i] = 0; end
      m_state = 0; ring_left = 0; snz_left = 0; m_id = 0;
    end else begin
      hit = 0; hid = 0;
      if (tick) begin
        if (timeset) begin
          m_min = (m_min + int'(minadv)) % 60;
          m_hrs = (m_hrs + int'(hrsadv)) % 24;
          m_day = (m_day + int'(dayadv)) % 7;
        end else if (alarmset) begin
          a_min[alarm_sel] = (a_min[alarm_sel] + int'(minadv)) % 60;
          a_hrs[alarm_sel] = (a_hrs[alarm_sel] + int'(hrsadv)) % 24;
        end else begin
          tot = (m_sec + 60 * m_min + 3600 * m_hrs + 86400 * m_day + 1) % WEEK;
          m_sec = tot % 60;
          m_min = (tot / 60) % 60;
          m_hrs = (tot / 3600) % 24;
          m_day = tot / 86400;
          for (int i = NA - 1; i >= 0; i--)
            if (alarm_en[i] && m_sec == 0 && m_min == a_min[i] && m_hrs == a_hrs[i]) begin
              hit = 1; hid = i;
            end
        end
      end
      case (m_state)
        0: if (hit) begin m_state = 1; ring_left = 60; m_id = hid; end
        1: begin
          if (dismiss) m_state = 0;
          else if (snooze) begin m_state = 2; snz_left = 9 * 60; end
          else if (tick) begin
            ring_left--;
            if (ring_left == 0) m_state = 0;
          end
        end
        default: begin
          if (dismiss) m_state = 0;
          else if (tick) begin
            snz_left--;
            if (snz_left == 0) begin m_state = 1; ring_left = 60; end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_vec++;
      if (sec !== 7'(m_sec) || min !== 7'(m_min) || hrs !== 7'(m_hrs) || day !== 3'(m_day) ||
          disp_min !== 7'(alarmset ? a_min[alarm_sel] : m_min) ||
          disp_hrs !== 7'(alarmset ? a_hrs[alarm_sel] : m_hrs) ||
          buzz !== (m_state == 1) || snoozing !== (m_state == 2) || buzz_id !== AW'(m_id)) begin
        n_bad++;
        $display("FAIL cycle t=%0t: dut %0d:%0d:%0d d%0d disp %0d:%0d buzz=%b id=%0d snz=%b | want %0d:%0d:%0d d%0d buzz=%b id=%0d snz=%b",
                 $time, hrs, min, sec, day, disp_hrs, disp_min, buzz, buzz_id, snoozing,
                 m_hrs, m_min, m_sec, m_day, m_state == 1, m_id, m_state == 2);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin cyc(1); cyc(0); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 0; chk_on = 1;
    @(posedge clk); @(posedge clk); #1 rst = 1;
    lit("reset_sec", sec, 0); lit("reset_hrs", hrs, 0); lit("reset_day", day, 0);
    lit("reset_buzz", buzz, 0); lit("reset_id", buzz_id, 0); lit("reset_snz", snoozing, 0);

    // Preload 23:59:59 day 6 and roll over the week.
    ticks(59);
    timeset = 1; minadv = 1; hrsadv = 1; dayadv = 1; ticks(6);
    dayadv = 0; ticks(17);
    hrsadv = 0; ticks(36);
    minadv = 0; timeset = 0;
    lit("pre_sec", sec, 59); lit("pre_min", min, 59); lit("pre_hrs", hrs, 23); lit("pre_day", day, 6);
    ticks(1);
    lit("wrap_sec", sec, 0); lit("wrap_min", min, 0); lit("wrap_hrs", hrs, 0);
    lit("wrap_day", day, 0); lit("wrap_buzz", buzz, 0);

    // Alarm0 07:30, approach from 07:29:58, ring, auto-stop after 60 ticks.
    alarmset = 1; alarm_sel = 0; hrsadv = 1; ticks(7); hrsadv = 0; minadv = 1; ticks(30);
    minadv = 0; alarmset = 0;
    timeset = 1; hrsadv = 1; ticks(7); hrsadv = 0; minadv = 1; ticks(29); minadv = 0; timeset = 0;
    ticks(58); alarm_en = 4'b0001;
    lit("t2_pre_sec", sec, 58); lit("t2_pre_min", min, 29); lit("t2_pre_hrs", hrs, 7);
    ticks(1);
    lit("t2_59_buzz", buzz, 0);
    cyc(1);
    lit("t2_ring_buzz", buzz, 1); lit("t2_ring_sec", sec, 0); lit("t2_ring_min", min, 30);
    lit("t2_ring_id", buzz_id, 0);
    cyc(0); ticks(59);
    lit("t2_59later_buzz", buzz, 1);
    ticks(1);
    lit("t2_autostop_buzz", buzz, 0);

    // Alarm1 07:32, snooze, re-ring after exactly 540 ticks.
    alarm_en = 4'b0010;
    alarmset = 1; alarm_sel = 1; hrsadv = 1; ticks(7); hrsadv = 0; minadv = 1; ticks(32);
    minadv = 0; alarmset = 0;
    ticks(59);
    lit("t3_pre_buzz", buzz, 0);
    cyc(1);
    lit("t3_ring_buzz", buzz, 1); lit("t3_ring_id", buzz_id, 1);
    snooze = 1; cyc(0); snooze = 0;
    lit("t3_snz_buzz", buzz, 0); lit("t3_snz_flag", snoozing, 1);
    ticks(539);
    lit("t3_539_snz", snoozing, 1); lit("t3_539_buzz", buzz, 0);
    cyc(1);
    lit("t3_540_buzz", buzz, 1); lit("t3_540_snz", snoozing, 0); lit("t3_540_id", buzz_id, 1);

    // Asynchronous reset between clock edges while ringing.
    cyc(0);
    #2 rst = 0;
    #1;
    lit("t6_buzz", buzz, 0); lit("t6_sec", sec, 0); lit("t6_min", min, 0);
    lit("t6_hrs", hrs, 0); lit("t6_day", day, 0); lit("t6_id", buzz_id, 0);
    alarm_en = '0;
    @(posedge clk); #1 rst = 1;

    // Alarm1 and alarm3 both 06:00: lowest index wins; dismiss beats snooze.
    alarmset = 1; hrsadv = 1; alarm_sel = 1; ticks(6); alarm_sel = 3; ticks(6); hrsadv = 0; alarmset = 0;
    timeset = 1; hrsadv = 1; ticks(5); hrsadv = 0; minadv = 1; ticks(59); minadv = 0; timeset = 0;
    alarm_en = 4'b1010;
    ticks(59);
    lit("t4_pre_buzz", buzz, 0);
    cyc(1);
    lit("t4_ring_buzz", buzz, 1); lit("t4_ring_id", buzz_id, 1); lit("t4_ring_hrs", hrs, 6);
    dismiss = 1; snooze = 1; cyc(0); dismiss = 0; snooze = 0;
    lit("t4_dis_buzz", buzz, 0); lit("t4_dis_snz", snoozing, 0);

    // Alarm-set editing of alarm2, time frozen; timeset+alarmset leaves the alarm alone.
    alarmset = 1; alarm_sel = 2; hrsadv = 1; ticks(5);
    lit("t5_disp_hrs", disp_hrs, 5); lit("t5_disp_min", disp_min, 0);
    lit("t5_sec", sec, 0); lit("t5_hrs", hrs, 6);
    timeset = 1; ticks(3);
    lit("t5_both_disp_hrs", disp_hrs, 5); lit("t5_both_hrs", hrs, 9);
    hrsadv = 0; timeset = 0; alarmset = 0;
    #1;
    lit("t5_disp_time", disp_hrs, 9);
    cyc(0); cyc(0);

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
